// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front-end onto a word memory; resp at +2 (load/word store), +3 (sub-word RMW), +1 (fault).
// One request in flight: req_ready only in IDLE, RESP holds until resp_ready. MEM_ACCESS_ALIGN_CHECK_EN adds misalignment faults.
module mem_access_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  logic [1:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] merge_q, merge_d;

  logic        accept;
  logic        req_fault;
  logic        word_store;
  logic [31:0] rd_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign word_store = write_q && (size_q == SZ_WORD);

  always_comb begin
    req_fault = (req_size == 2'd3) || ({2'b00, req_addr[31:2]} >= MEM_WORDS_L);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if ((req_size == SZ_HALF) && req_addr[0]) req_fault = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_fault = 1'b1;
`endif
  end

  // Lane selection ignores the low address bits a wider access does not use,
  // so unaligned accesses collapse onto the aligned lane when checks are off.
  assign rd_shift = mem_rd >> {addr_q[1:0], 3'b000};
  assign ld_byte  = rd_shift[7:0];
  assign ld_half  = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    case (size_q)
      SZ_BYTE: load_val = {{24{signed_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = {{16{signed_q & ld_half[15]}}, ld_half};
      default: load_val = mem_rd;
    endcase
  end

  always_comb begin
    merge_val = mem_rd;
    if (size_q == SZ_BYTE) merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    merge_d  = merge_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          fault_d  = req_fault;
          state_d  = req_fault ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!write_q) begin
          rdata_d = load_val;
          state_d = ST_RESP;
        end else if (size_q == SZ_WORD) begin
          state_d = ST_RESP;
        end else begin
          merge_d = merge_val;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      default: begin
        if (resp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
      merge_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      merge_q  <= merge_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

  // Reset gates the write strobe combinationally so an aborted RMW never lands.
  assign mem_we = !reset && (((state_q == ST_ACCESS) && word_store) || (state_q == ST_WRITE));
  assign mem_a  = ((state_q == ST_ACCESS) || (state_q == ST_WRITE)) ? {2'b00, addr_q[31:2]} : 32'h0;
  assign mem_wd = (state_q == ST_WRITE) ? merge_q :
                  ((state_q == ST_ACCESS) && word_store) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word bench-side memory.
// Expected values are hand-computed from the little-endian lane rules.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [32];
  logic        mem_clr;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_we(mem_we),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rd = (mem_a < 32) ? mem[mem_a[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (mem_we && (mem_a < 32)) begin
      mem[mem_a[4:0]] <= mem_wd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called right after the accept edge: counts cycles to resp_valid, then handshakes.
  task automatic finish_req(input int exp_lat, input logic [31:0] exp_rd, input logic exp_flt,
                            input int exp_we, input logic [31:0] exp_a, input logic [31:0] exp_wd,
                            input string tag);
    int lat = 0;
    int we_cnt = 0;
    logic [31:0] la = 32'h0;
    logic [31:0] lwd = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin
        we_cnt++;
        la = mem_a;
        lwd = mem_wd;
      end
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_fault"}, {31'b0, resp_fault}, {31'b0, exp_flt});
    chk({tag, "_we_cnt"}, 32'(we_cnt), 32'(exp_we));
    if (exp_we > 0) begin
      chk({tag, "_mem_a"}, la, exp_a);
      chk({tag, "_mem_wd"}, lwd, exp_wd);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_resp_clr"}, {31'b0, resp_valid}, 32'h0);
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_flt,
                        input int exp_we, input logic [31:0] exp_a, input logic [31:0] exp_wd,
                        input string tag);
    drive(w, sz, sg, addr, wd);
    #1;
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    finish_req(exp_lat, exp_rd, exp_flt, exp_we, exp_a, exp_wd, tag);
  endtask

  initial begin
    logic stray_valid;
    reset = 1'b1;
    mem_clr = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'd0;
    req_signed = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_fault", {31'b0, resp_fault}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    reset = 1'b0;
    mem_clr = 1'b0;
    #1;
    chk("idle_req_ready", {31'b0, req_ready}, 32'h1);

    // Word store / load round trip
    do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 32'd2, 32'hDEADBEEF, "str_w");
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 32'h0, 32'h0, "ldr_w");

    // Byte RMW
    do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'h11223344, 2, 32'h0, 1'b0, 1, 32'd2, 32'h11223344, "str_pre");
    do_req(1'b1, 2'd0, 1'b0, 32'h09, 32'h000000AA, 3, 32'h0, 1'b0, 1, 32'd2, 32'h1122AA44, "strb");
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 2, 32'h1122AA44, 1'b0, 0, 32'h0, 32'h0, "ldr_strb");

    // Extension patterns on 0x8000F0FF
    do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'h8000F0FF, 2, 32'h0, 1'b0, 1, 32'd2, 32'h8000F0FF, "str_ext");
    do_req(1'b0, 2'd0, 1'b1, 32'h08, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 0, 32'h0, 32'h0, "ldrb_s0");
    do_req(1'b0, 2'd0, 1'b1, 32'h09, 32'h0, 2, 32'hFFFFFFF0, 1'b0, 0, 32'h0, 32'h0, "ldrb_s1");
    do_req(1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, 2, 32'h00000080, 1'b0, 0, 32'h0, 32'h0, "ldrb_u3");
    do_req(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, 2, 32'h00008000, 1'b0, 0, 32'h0, 32'h0, "ldrh_u");
    do_req(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, 2, 32'hFFFF8000, 1'b0, 0, 32'h0, 32'h0, "ldrh_s");
    do_req(1'b0, 2'd2, 1'b1, 32'h08, 32'h0, 2, 32'h8000F0FF, 1'b0, 0, 32'h0, 32'h0, "ldr_sgn");

    // Upper-lane sub-word stores
    do_req(1'b1, 2'd1, 1'b0, 32'h0A, 32'hFFFF1234, 3, 32'h0, 1'b0, 1, 32'd2, 32'h1234F0FF, "strh_hi");
    do_req(1'b1, 2'd0, 1'b0, 32'h0B, 32'hFFFFFF55, 3, 32'h0, 1'b0, 1, 32'd2, 32'h5534F0FF, "strb_b3");

    // Faults and range boundary
    do_req(1'b1, 2'd2, 1'b0, 32'h04, 32'hCAFE1234, 2, 32'h0, 1'b0, 1, 32'd1, 32'hCAFE1234, "str_w1");
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    do_req(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0, "ldrh_misal");
`else
    do_req(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, 2, 32'h00001234, 1'b0, 0, 32'h0, 32'h0, "ldrh_misal");
`endif
    do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'h12345678, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0, "str_oor");
    do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0, "size3");
    do_req(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, 2, 32'h0, 1'b0, 0, 32'h0, 32'h0, "ldr_last");

    // Response backpressure with a queued request
    drive(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 2'd0, 1'b0, 32'h0B, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("bp_resp_valid", {31'b0, resp_valid}, 32'h1);
      chk("bp_resp_rdata", resp_rdata, 32'h5534F0FF);
      chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
      if (i < 3) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_resp_clr", {31'b0, resp_valid}, 32'h0);
    chk("bp_req_ready_after", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    finish_req(2, 32'h00000055, 1'b0, 0, 32'h0, 32'h0, "bp_next");

    // Reset during the WRITE cycle of a halfword store
    drive(1'b1, 2'd1, 1'b0, 32'h08, 32'h0000AAAA);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_access_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    chk("rst_mid_write_we_pre", {31'b0, mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_mid_write_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_idle", {31'b0, req_ready}, 32'h1);
    stray_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) stray_valid = 1'b1;
    end
    chk("rst_mid_no_resp", {31'b0, stray_valid}, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 2, 32'h5534F0FF, 1'b0, 0, 32'h0, 32'h0, "rst_mid_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end between the CPU memory stage and the word-addressed data memory.
- Takes byte-addressed LDR/STR/LDRB/STRB/LDRH/STRH requests over a valid/ready handshake.
- Converts each request to word-index accesses on a synchronous-write, combinational-read memory port.
- Sub-word stores use read-modify-write; loads are lane-extracted and zero- or sign-extended.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the attached data memory; valid word indices are 0..MEM_WORDS-1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 = illegal.
- req_signed  input  1  loads only: sign-extend (1) or zero-extend (0).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response available.
- resp_ready  input  1  CPU consumes the response.
- resp_rdata  output  32  load result; 0 for stores and faults.
- resp_fault  output  1  request was rejected (misaligned, out of range, or illegal size).
- mem_we  output  1  data memory write enable.
- mem_a  output  32  data memory word index = req_addr[31:2].
- mem_wd  output  32  data memory write data.
- mem_rd  input  32  data memory read data, combinational from mem_a.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state and values:
  - State is IDLE.
  - resp_valid=0, resp_fault=0, resp_rdata=0, mem_we=0, mem_a=0, mem_wd=0, req_ready=0.
  - mem_we is forced to 0 in any cycle where reset=1, regardless of state.
- Reset mid-operation: aborts the transaction. No memory write occurs and no response is issued.
- Request capture: all req_* fields are captured on the edge where req_valid && req_ready. req_ready=1 only in IDLE with reset=0.
- Request check at capture:
  - Fault if req_size==3.
  - Fault if halfword and addr[0]!=0.
  - Fault if word and addr[1:0]!=0.
  - Fault if addr[31:2] >= MEM_WORDS.
  - A faulting request goes IDLE->RESP with resp_fault=1 and never asserts mem_we.
- Byte lanes are little-endian:
  - byte lane = addr[1:0], bits [8k+7:8k];
  - half lane = addr[1], bits [16h+15:16h].
- State machine (IDLE, ACCESS, WRITE, RESP):
  - IDLE: on accept, go to ACCESS, or to RESP on fault.
  - ACCESS: mem_a = word index.
    - Load: latch the extracted and extended lane of mem_rd into resp_rdata; go to RESP.
    - Word store: mem_we=1, mem_wd=wdata; go to RESP.
    - Sub-word store: mem_we=0; latch mem_rd with the target lane replaced by wdata into a merge register; go to WRITE.
  - WRITE: mem_we=1, mem_a held, mem_wd = merge register; go to RESP.
  - RESP: resp_valid=1 with stable resp_rdata/resp_fault until resp_ready. On the edge where resp_valid && resp_ready, go to IDLE and clear resp_valid.
- mem_we is 1 only in ACCESS (word store) or WRITE, and for exactly one cycle per store.
- Latency from the accept edge (T) to the first resp_valid cycle:
  - load: T+2;
  - word store: T+2;
  - sub-word store: T+3;
  - fault: T+1.
- Back-to-back throughput: the earliest next accept is the cycle after the response handshake. resp_ready held high gives one load per 3 cycles.
- Sign extension: byte uses bit 7 and half uses bit 15 when req_signed=1. Word loads ignore req_signed.
- A store followed by a load to the same word must return the stored value. Guaranteed by serialization: the write lands before RESP.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: misalignment faults as described above.
- Undefined:
  - misaligned halfword/word requests do not fault;
  - halfword treats addr[0] as 0 and word treats addr[1:0] as 0;
  - out-of-range and size==3 checks remain.

Test Plan:
- Reset, then word store of 0xDEADBEEF at addr 0x08, then word load at 0x08 -> mem_we high one cycle with mem_a=2; load resp_rdata=0xDEADBEEF at T+2; resp_fault=0.
- Memory word 2 = 0x11223344; STRB of 0xAA at 0x09 -> read in ACCESS, write in WRITE of mem_wd=0x1122AA44; resp_valid at T+3.
- Word 2 = 0x8000F0FF: LDRB signed at 0x08 -> 0xFFFFFFFF; LDRH unsigned at 0x0A -> 0x00008000; LDRH signed at 0x0A -> 0xFFFF8000.
- Fault cases -> resp_fault=1 at T+1, mem_we never asserted:
  - halfword load at 0x05 with MEM_ACCESS_ALIGN_CHECK_EN;
  - word store at 0x80 (index 32, MEM_WORDS=32);
  - req_size=3.
- resp_ready held low 4 cycles -> resp_valid and resp_rdata stable, req_ready=0; accept only after the handshake.
- Reset asserted in the WRITE cycle of an STRH -> mem_we=0 that cycle, state IDLE, resp_valid never asserted, memory word unchanged.
